// File: rtl/fip_32_det_seq.sv
// Sequential 3x3 Q16.16 determinant: one shared multiplier and one shared add/sub
// unit stepped through 15 micro-steps (cofactor expansion along the first row).
module fip_32_det_seq #(
  parameter int FRAC_BITS = 16,
  parameter int N_STEPS   = 15
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [0:2][0:2][31:0]  i_array,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [31:0]            o_det,
  output logic                   o_overflow,
  output logic                   o_busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [3:0] LAST   = 4'(N_STEPS - 1);

  logic [1:0]            state;
  logic [3:0]            step;
  logic [0:2][0:2][31:0] mat;
  logic [31:0]           m1, m2, t, p, acc;
  logic                  ovf;

  logic [31:0]        mx, my, ax, ay, as_res;
  logic               as_sub, is_mul, is_as;
  logic signed [63:0] prod, shp;
  logic               mul_ovf, as_ovf, step_ovf;

  // Operand routing per micro-step; mat[r][c] is row-major a..i.
  always_comb begin
    mx = '0; my = '0; ax = m1; ay = m2;
    as_sub = 1'b1; is_mul = 1'b0; is_as = 1'b0;
    case (step)
      4'd0:  begin mx = mat[1][1]; my = mat[2][2]; is_mul = 1'b1; end
      4'd1:  begin mx = mat[1][2]; my = mat[2][1]; is_mul = 1'b1; end
      4'd3:  begin mx = mat[0][0]; my = t;         is_mul = 1'b1; end
      4'd5:  begin mx = mat[1][2]; my = mat[2][0]; is_mul = 1'b1; end
      4'd6:  begin mx = mat[1][0]; my = mat[2][2]; is_mul = 1'b1; end
      4'd8:  begin mx = mat[0][1]; my = t;         is_mul = 1'b1; end
      4'd10: begin mx = mat[1][0]; my = mat[2][1]; is_mul = 1'b1; end
      4'd11: begin mx = mat[1][1]; my = mat[2][0]; is_mul = 1'b1; end
      4'd13: begin mx = mat[0][2]; my = t;         is_mul = 1'b1; end
      4'd2, 4'd7, 4'd12: is_as = 1'b1;
      4'd9, 4'd14: begin ax = acc; ay = p; as_sub = 1'b0; is_as = 1'b1; end
      default: ;
    endcase
  end

  assign prod    = $signed(mx) * $signed(my);
  assign shp     = prod >>> FRAC_BITS;
  // Result fits in 32 bits only if everything above bit 31 is sign extension.
  assign mul_ovf = !((&shp[63:31]) || !(|shp[63:31]));

  assign as_res  = as_sub ? (ax - ay) : (ax + ay);
  assign as_ovf  = as_sub ? ((ax[31] != ay[31]) && (as_res[31] != ax[31]))
                          : ((ax[31] == ay[31]) && (as_res[31] != ax[31]));
  assign step_ovf = (is_mul & mul_ovf) | (is_as & as_ovf);

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state <= S_IDLE;
      step  <= '0;
      acc   <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (i_valid) begin
          mat   <= i_array;
          acc   <= '0;
          ovf   <= 1'b0;
          step  <= '0;
          state <= S_RUN;
        end
        S_RUN: begin
          ovf <= ovf | step_ovf;
          case (step)
            4'd0, 4'd5, 4'd10: m1  <= shp[31:0];
            4'd1, 4'd6, 4'd11: m2  <= shp[31:0];
            4'd3, 4'd8, 4'd13: p   <= shp[31:0];
            4'd2, 4'd7, 4'd12: t   <= as_res;
            4'd4:              acc <= p;
            4'd9, 4'd14:       acc <= as_res;
            default: ;
          endcase
          if (step == LAST) begin
            step  <= '0;
            state <= S_DONE;
          end else begin
            step <= step + 4'd1;
          end
        end
        S_DONE: if (i_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_ready    = (state == S_IDLE);
  assign o_valid    = (state == S_DONE);
  assign o_busy     = (state == S_RUN) || (state == S_DONE);
  assign o_det      = acc;
  assign o_overflow = ovf;

endmodule
